regfile_wb_arbiter: RTL and testbench

Write-back controller for the 32×32 register file: it shares the file's single write port between two producers (ALU and load/store unit) and maintains a busy scoreboard of destination registers awaiting write-back. Requesters hand off `{rd, data}` over valid/ready, and the block drives the register file's `reg_write`/`write_reg`/`write_data` from a registered output stage. It sits between the execute/memory stages and `registers`, and feeds hazard detection via `busy`.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/wb_arbiter2.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register file and its write-back controller.
//   XLEN        : data width
//   REG_ADDR_W  : register index width
//   NUM_REGS    : number of architectural registers (x0..x31)
//   wb_req_t    : one write-back request {rd, data}
//   wb_src_e    : write-back source identifier; its value is also the bit
//                 position of that source in the arbiter's one-hot grant
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter2.sv
// wb_arbiter2
// Two-way grant generator for the register-file write port.
// Build option: WB_RR_ARB_EN
//   defined   -> round-robin on contention, driven by the last-grant pointer
//   undefined -> fixed priority, LSU over ALU (no pointer input)
// Ports:
//   alu_valid  in   ALU request pending
//   lsu_valid  in   LSU request pending
//   last_grant in   source granted by the most recent transfer (RR build only)
//   grant      out  one-hot grant, bit index = wb_src_e value; zero when idle
module wb_arbiter2
    import regfile_pkg::*;
(
    input  logic       alu_valid,
    input  logic       lsu_valid,
`ifdef WB_RR_ARB_EN
    input  wb_src_e    last_grant,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (alu_valid && lsu_valid) begin
`ifdef WB_RR_ARB_EN
            // Contention: the requester that did not win last time goes now.
            if (last_grant == WB_ALU) begin
                grant[WB_LSU] = 1'b1;
            end else begin
                grant[WB_ALU] = 1'b1;
            end
`else
            grant[WB_LSU] = 1'b1;
`endif
        end else if (alu_valid) begin
            grant[WB_ALU] = 1'b1;
        end else if (lsu_valid) begin
            grant[WB_LSU] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-back controller for the 32x32 register file. Shares the single write
// port between the ALU and the LSU, drives reg_write/write_reg/write_data from
// a registered stage, and keeps a busy scoreboard for hazard detection.
// Build option: WB_RR_ARB_EN selects round-robin arbitration (otherwise fixed
// LSU-over-ALU priority, no pointer flop).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_valid/alu_ready/rd/data      ALU write-back handshake
//   lsu_valid/lsu_ready/rd/data      LSU write-back handshake
//   issue_valid, issue_rd            destination of an issuing instruction
//   busy                             scoreboard, bit i = write to x_i pending
//   reg_write, write_reg, write_data register-file write port
module regfile_wb_arbiter #(
    parameter int XLEN       = regfile_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REG_ADDR_W-1:0]         alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [REG_ADDR_W-1:0]         lsu_rd,
    input  logic [XLEN-1:0]               lsu_data,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    output logic [regfile_pkg::NUM_REGS-1:0] busy,
    output logic                          reg_write,
    output logic [REG_ADDR_W-1:0]         write_reg,
    output logic [XLEN-1:0]               write_data
);

    import regfile_pkg::*;

    logic [1:0]            grant;
    logic                  alu_xfer;
    logic                  lsu_xfer;
    logic                  wb_xfer;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

    logic                  reg_write_reg;
    logic [REG_ADDR_W-1:0] write_reg_reg;
    logic [XLEN-1:0]       write_data_reg;
    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;

`ifdef WB_RR_ARB_EN
    wb_src_e last_grant_reg;

    wb_arbiter2 u_arb (
        .alu_valid  (alu_valid),
        .lsu_valid  (lsu_valid),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    // Reset to "LSU granted last" so the first contention goes to the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= WB_LSU;
        end else if (wb_xfer) begin
            last_grant_reg <= lsu_xfer ? WB_LSU : WB_ALU;
        end
    end
`else
    wb_arbiter2 u_arb (
        .alu_valid  (alu_valid),
        .lsu_valid  (lsu_valid),
        .grant      (grant)
    );
`endif

    // Grant already implies valid; rst_n keeps both handshakes closed while
    // the block is held in reset.
    assign alu_ready = grant[WB_ALU] & rst_n;
    assign lsu_ready = grant[WB_LSU] & rst_n;

    assign alu_xfer = alu_valid & alu_ready;
    assign lsu_xfer = lsu_valid & lsu_ready;
    assign wb_xfer  = alu_xfer | lsu_xfer;
    assign wb_rd    = lsu_xfer ? lsu_rd   : alu_rd;
    assign wb_data  = lsu_xfer ? lsu_data : alu_data;

    // Per-register scoreboard update. A same-cycle issue to rd overrides the
    // clear from a write-back to rd, since a newer producer now owns it.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_bit
            logic set_hit;
            logic clr_hit;
            assign set_hit = issue_valid && (issue_rd == REG_ADDR_W'(gi));
            assign clr_hit = wb_xfer && (wb_rd == REG_ADDR_W'(gi));
            assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
        end
    end

    // Output stage: writes to x0 are consumed without touching the port,
    // and the index/data hold their last values when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_reg  <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
            busy_reg       <= '0;
        end else begin
            busy_reg      <= busy_next;
            reg_write_reg <= wb_xfer && (wb_rd != '0);
            if (wb_xfer && (wb_rd != '0)) begin
                write_reg_reg  <= wb_rd;
                write_data_reg <= wb_data;
            end
        end
    end

    assign reg_write  = reg_write_reg;
    assign write_reg  = write_reg_reg;
    assign write_data = write_data_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Table-driven bench for regfile_wb_arbiter. Each vector drives one cycle of
// requests/issue and states the expected readies; a small model turns the
// vector into the expected registered outputs, which are queued and compared
// one cycle later. A behavioural register file follows the write port so
// write-back results can be read back.
module tb_regfile_wb_arbiter;

    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, issue_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, issue_rd;
    logic [31:0] alu_data, lsu_data;
    logic [31:0] busy;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data)
    );

    // Behavioural register file fed by the DUT's write port.
    logic [31:0] tb_regs [0:31];
    always @(posedge clk) begin
        if (reg_write) tb_regs[write_reg] <= write_data;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        iv;
        logic [4:0]  ird;
        logic        exp_ar;
        logic        exp_lr;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] busy;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    // Model state
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic [31:0] m_busy;

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                input logic iv, input logic [4:0] ird,
                                input logic exp_ar, input logic exp_lr);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.iv = iv; v.ird = ird;
        v.exp_ar = exp_ar; v.exp_lr = exp_lr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        m_wr = '0; m_wd = '0; m_busy = '0;
        e.rw = 1'b0; e.wr = '0; e.wd = '0; e.busy = '0;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: scoreboard empty, actual reg_write=%0b required an expectation", tag, reg_write);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".reg_write"},  {31'd0, reg_write}, {31'd0, e.rw});
            chk({tag, ".write_reg"},  {27'd0, write_reg}, {27'd0, e.wr});
            chk({tag, ".write_data"}, write_data, e.wd);
            chk({tag, ".busy"},       busy, e.busy);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic apply(input string tag, input vec_t v);
        exp_t        e;
        logic        ax, lx;
        logic [4:0]  rd;
        logic [31:0] d;
        check_outputs(tag);
        alu_valid   = v.av; alu_rd = v.ard; alu_data = v.adata;
        lsu_valid   = v.lv; lsu_rd = v.lrd; lsu_data = v.ldata;
        issue_valid = v.iv; issue_rd = v.ird;
        #1;
        chk({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, v.exp_ar});
        chk({tag, ".lsu_ready"}, {31'd0, lsu_ready}, {31'd0, v.exp_lr});
        ax = v.av & v.exp_ar;
        lx = v.lv & v.exp_lr;
        rd = lx ? v.lrd : v.ard;
        d  = lx ? v.ldata : v.adata;
        e.rw = 1'b0;
        if ((ax || lx) && rd != 5'd0) begin
            e.rw = 1'b1;
            m_wr = rd;
            m_wd = d;
        end
        if (ax || lx) m_busy[rd] = 1'b0;
        if (v.iv && v.ird != 5'd0) m_busy[v.ird] = 1'b1;
        e.wr = m_wr; e.wd = m_wd; e.busy = m_busy;
        exp_q.push_back(e);
        $display("%s: alu_v=%0b rd=%0d d=%0d lsu_v=%0b rd=%0d d=%0d issue=%0b/%0d -> alu_rdy=%0b lsu_rdy=%0b",
                 tag, v.av, v.ard, v.adata, v.lv, v.lrd, v.ldata, v.iv, v.ird, alu_ready, lsu_ready);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) tb_regs[i] = 32'd0;

        // Main sequence
        tbl.push_back(mk(1, 7, 2022, 0, 0, 0,    0, 0,  1, 0)); // 0 ALU only
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  0, 0)); // 1 idle
        tbl.push_back(mk(0, 0, 0,    1, 3, 99,   0, 0,  0, 1)); // 2 LSU only
`ifdef WB_RR_ARB_EN
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 1, 0)); // 3-6 contention
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 0, 1));
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 1, 0));
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 0, 1));
`else
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 0, 1));
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 0, 1));
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 0, 1));
        tbl.push_back(mk(1, 10, 1,   1, 17, 2023, 0, 0, 0, 1));
`endif
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  0, 0)); // 7 idle
        tbl.push_back(mk(0, 0, 0,    1, 0, 55,   0, 0,  0, 1)); // 8 x0 drop
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  0, 0)); // 9 idle
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    1, 17, 0, 0)); // 10 issue x17
        tbl.push_back(mk(1, 17, 5,   0, 0, 0,    0, 0,  1, 0)); // 11 clear x17
        tbl.push_back(mk(1, 17, 6,   0, 0, 0,    1, 17, 1, 0)); // 12 set+clear x17
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    1, 0,  0, 0)); // 13 issue x0
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    1, 9,  0, 0)); // 14 issue x9
        tbl.push_back(mk(0, 0, 0,    1, 9, 301,  1, 4,  0, 1)); // 15 clear x9, set x4
        tbl.push_back(mk(0, 0, 0,    0, 0, 0,    0, 0,  0, 0)); // 16 idle

        // Reset held with a pending ALU request
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd2022;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        repeat (2) @(negedge clk);
        chk("reset.alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("reset.lsu_ready", {31'd0, lsu_ready}, 32'd0);
        model_reset();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Read-back through the register file
        chk("readback.x7",  tb_regs[7],  32'd2022);
        chk("readback.x3",  tb_regs[3],  32'd99);
        chk("readback.x17", tb_regs[17], 32'd6);
        chk("readback.x9",  tb_regs[9],  32'd301);
`ifdef WB_RR_ARB_EN
        chk("readback.x10", tb_regs[10], 32'd1);
`else
        chk("readback.x10", tb_regs[10], 32'd0);
`endif

        // Mid-operation reset: transfer, then reset while the write is on the port
        apply("midrst.req", mk(1, 12, 777, 0, 0, 0, 0, 0, 1, 0));
        check_outputs("midrst.drive");
        alu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.reg_write",  {31'd0, reg_write}, 32'd0);
        chk("midrst.write_reg",  {27'd0, write_reg}, 32'd0);
        chk("midrst.write_data", write_data, 32'd0);
        chk("midrst.busy",       busy, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst.x12_unchanged", tb_regs[12], 32'd0);
        exp_q.delete();
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Pointer after reset is ALU-preferred
`ifdef WB_RR_ARB_EN
        apply("post0", mk(1, 20, 11, 1, 21, 22, 0, 0, 1, 0));
        apply("post1", mk(0, 20, 11, 1, 21, 22, 0, 0, 0, 1));
`else
        apply("post0", mk(1, 20, 11, 1, 21, 22, 0, 0, 0, 1));
        apply("post1", mk(1, 20, 11, 0, 21, 22, 0, 0, 1, 0));
`endif
        apply("post2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_outputs("final");
        chk("readback.x20", tb_regs[20], 32'd11);
        chk("readback.x21", tb_regs[21], 32'd22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
